// File: rtl/zssd_disparity_scheduler.sv
// zssd_disparity_scheduler
// Sequences the ZSSD datapath for one stereo match point. For each candidate
// disparity it accumulates the five window sums over 256 pixel pairs, lets
// the external formula block settle for one cycle, registers its result and
// keeps the lowest-cost disparity (ties keep the lower index).
// Optional feature: define ZSSD_SCHED_EARLY_EXIT_EN to stop the search as
// soon as a zero-cost disparity is found.
module zssd_disparity_scheduler #(
    parameter int WIN_PIXELS = 256,
    parameter int MAX_DISP   = 64,
    parameter int DISP_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DISP_W-1:0] disp_idx,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        f_pix,
    input  logic [7:0]        g_pix,
    output logic [31:0]       fsum,
    output logic [31:0]       f2sum,
    output logic [31:0]       gsum,
    output logic [31:0]       g2sum,
    output logic [31:0]       fgsum,
    input  logic [31:0]       zssd_in,
    output logic [DISP_W-1:0] best_disp,
    output logic [31:0]       best_zssd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_EVAL,
        S_CMP,
        S_FIN
    } state_t;

    localparam logic [8:0]        LAST_PIX  = 9'(WIN_PIXELS - 1);
    localparam logic [DISP_W-1:0] LAST_DISP = DISP_W'(MAX_DISP - 1);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pix_ready_q, pix_ready_d;
    logic [DISP_W-1:0] disp_idx_q, disp_idx_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [31:0]       fsum_q, fsum_d;
    logic [31:0]       f2sum_q, f2sum_d;
    logic [31:0]       gsum_q, gsum_d;
    logic [31:0]       g2sum_q, g2sum_d;
    logic [31:0]       fgsum_q, fgsum_d;
    logic [31:0]       zssd_reg_q, zssd_reg_d;
    logic [DISP_W-1:0] best_disp_q, best_disp_d;
    logic [31:0]       best_zssd_q, best_zssd_d;

    logic [15:0] ff_prod, gg_prod, fg_prod;
    logic        last_disp;

    // Unsigned 8x8 products widened before multiplying so no bits are lost.
    always_comb begin
        ff_prod = {8'd0, f_pix} * {8'd0, f_pix};
        gg_prod = {8'd0, g_pix} * {8'd0, g_pix};
        fg_prod = {8'd0, f_pix} * {8'd0, g_pix};
    end

    // Next-state and next-output logic for the search sequencer.
    always_comb begin
        // NOTE: every _d gets a default here so no path leaves it unassigned (no latches).
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_ready_d = pix_ready_q;
        disp_idx_d  = disp_idx_q;
        cnt_d       = cnt_q;
        fsum_d      = fsum_q;
        f2sum_d     = f2sum_q;
        gsum_d      = gsum_q;
        g2sum_d     = g2sum_q;
        fgsum_d     = fgsum_q;
        zssd_reg_d  = zssd_reg_q;
        best_disp_d = best_disp_q;
        best_zssd_d = best_zssd_q;
        last_disp   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ACCUM;
                    busy_d      = 1'b1;
                    pix_ready_d = 1'b1;
                    disp_idx_d  = '0;
                    cnt_d       = '0;
                    fsum_d      = '0;
                    f2sum_d     = '0;
                    gsum_d      = '0;
                    g2sum_d     = '0;
                    fgsum_d     = '0;
                end
            end
            S_ACCUM: begin
                if (pix_valid && pix_ready_q) begin
                    fsum_d  = fsum_q  + {24'd0, f_pix};
                    f2sum_d = f2sum_q + {16'd0, ff_prod};
                    gsum_d  = gsum_q  + {24'd0, g_pix};
                    g2sum_d = g2sum_q + {16'd0, gg_prod};
                    fgsum_d = fgsum_q + {16'd0, fg_prod};
                    cnt_d   = cnt_q + 9'd1;
                    if (cnt_q == LAST_PIX) begin
                        state_d     = S_EVAL;
                        pix_ready_d = 1'b0;
                    end
                end
            end
            S_EVAL: begin
                // Sums are frozen here, so the formula block output has settled.
                zssd_reg_d = zssd_in;
                state_d    = S_CMP;
            end
            S_CMP: begin
                if ((disp_idx_q == '0) || (zssd_reg_q < best_zssd_q)) begin
                    best_zssd_d = zssd_reg_q;
                    best_disp_d = disp_idx_q;
                end
                last_disp = (disp_idx_q == LAST_DISP);
`ifdef ZSSD_SCHED_EARLY_EXIT_EN
                if (best_zssd_d == 32'd0) begin
                    last_disp = 1'b1;
                end
`else
`endif
                if (last_disp) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d     = S_ACCUM;
                    pix_ready_d = 1'b1;
                    disp_idx_d  = disp_idx_q + DISP_W'(1);
                    cnt_d       = '0;
                    fsum_d      = '0;
                    f2sum_d     = '0;
                    gsum_d      = '0;
                    g2sum_d     = '0;
                    fgsum_d     = '0;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any search.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_ready_q <= 1'b0;
            disp_idx_q  <= '0;
            cnt_q       <= '0;
            fsum_q      <= '0;
            f2sum_q     <= '0;
            gsum_q      <= '0;
            g2sum_q     <= '0;
            fgsum_q     <= '0;
            zssd_reg_q  <= '0;
            best_disp_q <= '0;
            best_zssd_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_ready_q <= pix_ready_d;
            disp_idx_q  <= disp_idx_d;
            cnt_q       <= cnt_d;
            fsum_q      <= fsum_d;
            f2sum_q     <= f2sum_d;
            gsum_q      <= gsum_d;
            g2sum_q     <= g2sum_d;
            fgsum_q     <= fgsum_d;
            zssd_reg_q  <= zssd_reg_d;
            best_disp_q <= best_disp_d;
            best_zssd_q <= best_zssd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_ready = pix_ready_q;
    assign disp_idx  = disp_idx_q;
    assign fsum      = fsum_q;
    assign f2sum     = f2sum_q;
    assign gsum      = gsum_q;
    assign g2sum     = g2sum_q;
    assign fgsum     = fgsum_q;
    assign best_disp = best_disp_q;
    assign best_zssd = best_zssd_q;

endmodule

// File: tb/tb_zssd_disparity_scheduler.sv
// Testbench for zssd_disparity_scheduler (reduced to 8 disparities).
// Emulates the formula block and the pixel fetch unit; table-driven searches
// plus hand-written reset-abort and mid-search start sequences.
`timescale 1ns/1ps
module tb_zssd_disparity_scheduler;

    localparam int MAX_DISP = 8;
    localparam int DISP_W   = 3;
    localparam int WIN      = 256;
    localparam int FULL_CYC = MAX_DISP * 258 + 1;
`ifdef ZSSD_SCHED_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [DISP_W-1:0] disp_idx;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        f_pix;
    logic [7:0]        g_pix;
    logic [31:0]       fsum, f2sum, gsum, g2sum, fgsum;
    logic [31:0]       zssd_in;
    logic [DISP_W-1:0] best_disp;
    logic [31:0]       best_zssd;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    zssd_disparity_scheduler #(
        .WIN_PIXELS(WIN),
        .MAX_DISP  (MAX_DISP),
        .DISP_W    (DISP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .disp_idx (disp_idx),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .f_pix    (f_pix),
        .g_pix    (g_pix),
        .fsum     (fsum),
        .f2sum    (f2sum),
        .gsum     (gsum),
        .g2sum    (g2sum),
        .fgsum    (fgsum),
        .zssd_in  (zssd_in),
        .best_disp(best_disp),
        .best_zssd(best_zssd)
    );

    // Formula block: N*sum((f-g)^2) - (sum f - sum g)^2, with N = 256.
    function automatic logic [31:0] formula(input logic [31:0] fs, input logic [31:0] f2,
                                            input logic [31:0] gs, input logic [31:0] g2,
                                            input logic [31:0] fg);
        longint q, d;
        q = (longint'(f2) + longint'(g2) - 2 * longint'(fg)) * 256;
        d = longint'(fs) - longint'(gs);
        return 32'(q - d * d);
    endfunction

    assign zssd_in = formula(fsum, f2sum, gsum, g2sum, fgsum);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pixel pattern generator: 0 single-pixel f=16, 1 match at disp 5, 2 constant f=g.
    task automatic gen(input int mode, input int d, input int i,
                       output logic [7:0] f, output logic [7:0] g);
        case (mode)
            0: begin
                f = (i == 0) ? 8'd16 : 8'd0;
                g = 8'd0;
            end
            1: begin
                if (d == 5) begin
                    f = 8'd100;
                    g = 8'd100;
                end else begin
                    f = 8'($urandom);
                    g = 8'($urandom);
                end
            end
            default: begin
                f = 8'd77;
                g = 8'd77;
            end
        endcase
    endtask

    typedef struct {
        int     mode;
        bit     stall;
        bit     mid_start;
        int     exp_disp;
        longint exp_zssd;
        int     exp_cycles;
        int     exp_xfers;
    } vec_t;

    vec_t vecs[5];

    task automatic run_search(input vec_t v, input bit abort, input string tag);
        int     cyc, idx, xfers, exp_d, extra;
        bit     busy_ok, got_done, pend;
        longint ms_f, ms_f2, ms_g, ms_g2, ms_fg;
        logic [7:0] f, g;
        @(negedge clk);
        start     = 1'b1;
        pix_valid = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        idx      = 0;
        xfers    = 0;
        exp_d    = 0;
        busy_ok  = 1'b1;
        got_done = 1'b0;
        pend     = 1'b0;
        ms_f = 0; ms_f2 = 0; ms_g = 0; ms_g2 = 0; ms_fg = 0;
        while (cyc < 20000) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (pend) begin
                check({tag, " disp_idx"}, 64'(disp_idx), 64'(exp_d));
                check({tag, " fsum"},  64'(fsum),  ms_f);
                check({tag, " f2sum"}, 64'(f2sum), ms_f2);
                check({tag, " gsum"},  64'(gsum),  ms_g);
                check({tag, " g2sum"}, 64'(g2sum), ms_g2);
                check({tag, " fgsum"}, 64'(fgsum), ms_fg);
                pend = 1'b0;
                ms_f = 0; ms_f2 = 0; ms_g = 0; ms_g2 = 0; ms_fg = 0;
                exp_d++;
            end
            if (v.mid_start) start = (cyc == 600);
            pix_valid = v.stall ? (cyc % 2 == 1) : 1'b1;
            gen(v.mode, int'(disp_idx), idx, f, g);
            f_pix = f;
            g_pix = g;
            if (pix_valid && pix_ready) begin
                ms_f  += longint'(f);
                ms_f2 += longint'(f) * longint'(f);
                ms_g  += longint'(g);
                ms_g2 += longint'(g) * longint'(g);
                ms_fg += longint'(f) * longint'(g);
                idx++;
                xfers++;
                if (idx == WIN) begin
                    pend = 1'b1;
                    idx  = 0;
                end
            end
            if (abort && exp_d == 3 && idx == 100) begin
                rst = 1'b1;
                @(negedge clk);
                rst       = 1'b0;
                pix_valid = 1'b0;
                check({tag, " busy after rst"},      64'(busy),      0);
                check({tag, " disp_idx after rst"},  64'(disp_idx),  0);
                check({tag, " fsum after rst"},      64'(fsum),      0);
                check({tag, " fgsum after rst"},     64'(fgsum),     0);
                check({tag, " best_disp after rst"}, 64'(best_disp), 0);
                check({tag, " best_zssd after rst"}, 64'(best_zssd), 0);
                check({tag, " pix_ready after rst"}, 64'(pix_ready), 0);
                extra = 0;
                repeat (300) begin
                    if (done) extra++;
                    @(negedge clk);
                end
                check({tag, " no done after rst"}, 64'(extra), 0);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        check({tag, " done seen"}, 64'(got_done), 1);
        if (!v.stall) check({tag, " start-to-done cycles"}, 64'(cyc), 64'(v.exp_cycles));
        check({tag, " transfers"},   64'(xfers),     64'(v.exp_xfers));
        check({tag, " busy held"},   64'(busy_ok),   1);
        check({tag, " busy at done"}, 64'(busy),     0);
        check({tag, " best_disp"},   64'(best_disp), 64'(v.exp_disp));
        check({tag, " best_zssd"},   64'(best_zssd), v.exp_zssd);
        @(negedge clk);
        extra = 0;
        repeat (300) begin
            if (done) extra++;
            @(negedge clk);
        end
        check({tag, " single done pulse"}, 64'(extra), 0);
        check({tag, " best_disp held"}, 64'(best_disp), 64'(v.exp_disp));
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 1'b0, 0, 65280, FULL_CYC, MAX_DISP * WIN};
        vecs[1] = '{1, 1'b0, 1'b0, 5, 0, EE ? 6 * 258 + 1 : FULL_CYC,
                    EE ? 6 * WIN : MAX_DISP * WIN};
        vecs[2] = '{2, 1'b0, 1'b0, 0, 0, EE ? 259 : FULL_CYC,
                    EE ? WIN : MAX_DISP * WIN};
        vecs[3] = '{1, 1'b1, 1'b0, 5, 0, 0, EE ? 6 * WIN : MAX_DISP * WIN};
        vecs[4] = '{0, 1'b0, 1'b1, 0, 65280, FULL_CYC, MAX_DISP * WIN};

        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        f_pix     = 8'd0;
        g_pix     = 8'd0;
        repeat (3) @(negedge clk);
        check("reset busy",      64'(busy),      0);
        check("reset done",      64'(done),      0);
        check("reset pix_ready", 64'(pix_ready), 0);
        check("reset disp_idx",  64'(disp_idx),  0);
        check("reset f2sum",     64'(f2sum),     0);
        check("reset best_zssd", 64'(best_zssd), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 64'(busy), 0);

        for (int k = 0; k < 5; k++) begin
            run_search(vecs[k], 1'b0, $sformatf("vec%0d", k));
        end

        run_search(vecs[1], 1'b1, "abort");
        run_search(vecs[1], 1'b0, "after-abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
